// File: rtl/up_down_sweep_ctrl_if.sv
// Handshake/bus bundle for the triangle-sweep controller: run controls and bounds in, counter and status pulses out.
// The DUT side takes the slave modport; stimulus generators take the master modport.
interface up_down_sweep_ctrl_if #(
  parameter int N    = 4,
  parameter int SW_W = 8
);
  logic            start;
  logic            abort;
  logic            hold;
  logic [N-1:0]    lo;
  logic [N-1:0]    hi;
  logic [SW_W-1:0] num_sweeps;
  logic [N-1:0]    count;
  logic            up_down;
  logic            busy;
  logic            sweep_done;
  logic            done;
  logic            err;

  modport master (
    output start, abort, hold, lo, hi, num_sweeps,
    input  count, up_down, busy, sweep_done, done, err
  );

  modport slave (
    input  start, abort, hold, lo, hi, num_sweeps,
    output count, up_down, busy, sweep_done, done, err
  );
endinterface

// File: rtl/up_down_sweep_ctrl.sv
// Runs num_sweeps lo->hi->lo triangles on a registered counter; every output registered, one edge per step.
// hold freezes the run in place (abort still wins); start is only honoured while idle.
module up_down_sweep_ctrl #(
  parameter int N    = 4,
  parameter int SW_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  up_down_sweep_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  localparam logic [N-1:0]    CNT_ONE  = N'(1);
  localparam logic [SW_W-1:0] LEFT_ONE = SW_W'(1);

  state_t          state_q, state_d;
  logic [N-1:0]    count_q, count_d;
  logic            up_down_q, up_down_d;
  logic            busy_q, busy_d;
  logic            sweep_done_q, sweep_done_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [N-1:0]    lo_r, lo_d;
  logic [N-1:0]    hi_r, hi_d;
  logic [SW_W-1:0] left_r, left_d;

  logic [N-1:0]    cnt_inc;
  logic [N-1:0]    cnt_dec;

  assign cnt_inc = count_q + CNT_ONE;
  assign cnt_dec = count_q - CNT_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      up_down_q    <= 1'b1;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      lo_r         <= '0;
      hi_r         <= '0;
      left_r       <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      up_down_q    <= up_down_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
      done_q       <= done_d;
      err_q        <= err_d;
      lo_r         <= lo_d;
      hi_r         <= hi_d;
      left_r       <= left_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    up_down_d    = up_down_q;
    busy_d       = busy_q;
    sweep_done_d = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    lo_d         = lo_r;
    hi_d         = hi_r;
    left_d       = left_r;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if ((bus.lo < bus.hi) && (bus.num_sweeps != '0)) begin
            lo_d      = bus.lo;
            hi_d      = bus.hi;
            left_d    = bus.num_sweeps;
            count_d   = bus.lo;
            up_down_d = 1'b1;
            busy_d    = 1'b1;
            state_d   = UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      UP, DOWN: begin
        if (bus.abort) begin
          busy_d    = 1'b0;
          up_down_d = 1'b1;
          state_d   = IDLE;
        end else if (!bus.hold) begin
          if (state_q == UP) begin
            count_d = cnt_inc;
            // Turn around on the edge that reaches hi so direction is already down while count == hi.
            if (cnt_inc == hi_r) begin
              up_down_d = 1'b0;
              state_d   = DOWN;
            end
          end else begin
            count_d = cnt_dec;
            if (cnt_dec == lo_r) begin
              sweep_done_d = 1'b1;
              left_d       = left_r - LEFT_ONE;
              up_down_d    = 1'b1;
              if (left_r == LEFT_ONE) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
              end else begin
                state_d = UP;
              end
            end
          end
        end
      end

      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        up_down_d = 1'b1;
      end
    endcase
  end

  assign bus.count      = count_q;
  assign bus.up_down    = up_down_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_up_down_sweep_ctrl.sv
// Bench for up_down_sweep_ctrl: a per-edge vector table for rejects and a single sweep, then hand-written
// sequences for hold, full-range two-sweep, abort and asynchronous reset.
module tb_up_down_sweep_ctrl;

  localparam int N    = 4;
  localparam int SW_W = 8;

  logic clk;
  logic reset;

  up_down_sweep_ctrl_if #(.N(N), .SW_W(SW_W)) bus ();

  up_down_sweep_ctrl #(.N(N), .SW_W(SW_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       start;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] num;
    logic [3:0] e_count;
    logic       e_ud;
    logic       e_busy;
    logic       e_sd;
    logic       e_done;
    logic       e_err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic st, input logic [3:0] l, input logic [3:0] h, input logic [7:0] n);
    bus.start      = st;
    bus.lo         = l;
    bus.hi         = h;
    bus.num_sweeps = n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sd_cnt, done_cnt, sd_first, sd_second, done_edge, wraps, hold_done_edge;
    logic [3:0] prev;

    // start, lo, hi, num  ->  count, up_down, busy, sweep_done, done, err (after the edge)
    vecs[0]  = '{1'b1, 4'd7, 4'd7, 8'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 4'd7, 4'd7, 8'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'd3, 4'd6, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 4'd2, 4'd5, 8'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'd2, 4'd5, 8'd1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'd0, 4'd15, 8'd3, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'd2, 4'd5, 8'd1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'd2, 4'd5, 8'd1, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'd2, 4'd5, 8'd1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'd2, 4'd5, 8'd1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'd2, 4'd5, 8'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    reset     = 1'b1;
    bus.abort = 1'b0;
    bus.hold  = 1'b0;
    set_in(1'b0, 4'd0, 4'd0, 8'd0);
    step();
    step();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_up_down", 32'(bus.up_down), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pulses", {29'd0, bus.sweep_done, bus.done, bus.err}, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].start, vecs[i].lo, vecs[i].hi, vecs[i].num);
      step();
      chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(vecs[i].e_count));
      chk($sformatf("v%0d_up_down", i), 32'(bus.up_down), 32'(vecs[i].e_ud));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_sweep_done", i), 32'(bus.sweep_done), 32'(vecs[i].e_sd));
      chk($sformatf("v%0d_done", i), 32'(bus.done), 32'(vecs[i].e_done));
      chk($sformatf("v%0d_err", i), 32'(bus.err), 32'(vecs[i].e_err));
    end

    // Hold three cycles at count 4 while counting up: done lands 13 edges after acceptance.
    set_in(1'b1, 4'd1, 4'd6, 8'd1);
    step();
    set_in(1'b0, 4'd1, 4'd6, 8'd1);
    chk("hold_start_count", 32'(bus.count), 32'd1);
    step(); step(); step();
    chk("hold_pre_count", 32'(bus.count), 32'd4);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold%0d_count", i), 32'(bus.count), 32'd4);
      chk($sformatf("hold%0d_up_down", i), 32'(bus.up_down), 32'd1);
    end
    bus.hold = 1'b0;
    hold_done_edge = -1;
    for (int e = 7; e <= 40; e++) begin
      step();
      if (bus.done && hold_done_edge < 0) hold_done_edge = e;
    end
    chk("hold_done_edge", 32'(hold_done_edge), 32'd13);
    chk("hold_end_count", 32'(bus.count), 32'd1);

    // Full range, two sweeps.
    set_in(1'b1, 4'd0, 4'd15, 8'd2);
    step();
    set_in(1'b0, 4'd0, 4'd15, 8'd2);
    chk("full_start_count", 32'(bus.count), 32'd0);
    sd_cnt = 0; done_cnt = 0; sd_first = -1; sd_second = -1; done_edge = -1; wraps = 0;
    prev = bus.count;
    for (int e = 1; e <= 70; e++) begin
      step();
      if ((prev == 4'd15 && bus.count == 4'd0) || (prev == 4'd0 && bus.count == 4'd15)) wraps++;
      if (bus.count == 4'd15 && bus.up_down !== 1'b0) wraps++;
      prev = bus.count;
      if (bus.sweep_done) begin
        sd_cnt++;
        if (sd_first < 0) sd_first = e; else sd_second = e;
      end
      if (bus.done) begin
        done_cnt++;
        done_edge = e;
        chk("full_busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
    chk("full_sd_count", 32'(sd_cnt), 32'd2);
    chk("full_sd_first", 32'(sd_first), 32'd30);
    chk("full_sd_gap", 32'(sd_second - sd_first), 32'd30);
    chk("full_done_count", 32'(done_cnt), 32'd1);
    chk("full_done_edge", 32'(done_edge), 32'd60);
    chk("full_wraps", 32'(wraps), 32'd0);

    // Abort at count 4 while counting down, with an ignored start mid-run.
    set_in(1'b1, 4'd2, 4'd6, 8'd1);
    step();
    set_in(1'b0, 4'd2, 4'd6, 8'd1);
    step(); step();
    set_in(1'b1, 4'd0, 4'd9, 8'd1);
    step();
    set_in(1'b0, 4'd2, 4'd6, 8'd1);
    step(); step(); step();
    chk("abort_pre_count", 32'(bus.count), 32'd4);
    chk("abort_pre_up_down", 32'(bus.up_down), 32'd0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_count", 32'(bus.count), 32'd4);
    chk("abort_up_down", 32'(bus.up_down), 32'd1);
    chk("abort_no_done", {30'd0, bus.done, bus.sweep_done}, 32'd0);
    step();
    chk("abort_idle_count", 32'(bus.count), 32'd4);
    set_in(1'b1, 4'd2, 4'd3, 8'd1);
    step();
    set_in(1'b0, 4'd2, 4'd3, 8'd1);
    chk("restart_count", 32'(bus.count), 32'd2);
    chk("restart_busy", 32'(bus.busy), 32'd1);
    step();
    chk("restart_hi_count", 32'(bus.count), 32'd3);
    chk("restart_hi_up_down", 32'(bus.up_down), 32'd0);
    step();
    chk("restart_done", {30'd0, bus.done, bus.busy}, 32'd2);

    // Asynchronous reset mid-UP at count 4, checked before the next rising edge.
    set_in(1'b1, 4'd0, 4'd9, 8'd1);
    step();
    set_in(1'b0, 4'd0, 4'd9, 8'd1);
    step(); step(); step(); step();
    chk("areset_pre_count", 32'(bus.count), 32'd4);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_count", 32'(bus.count), 32'd0);
    chk("areset_busy", 32'(bus.busy), 32'd0);
    chk("areset_up_down", 32'(bus.up_down), 32'd1);
    step();
    reset = 1'b0;
    step(); step(); step();
    chk("post_reset_idle", {27'd0, bus.count, bus.busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
